seven_seg_reader: RTL

- Receive-side counterpart of the hex-to-7-segment decoder.
- Snoops a time-multiplexed 7-segment bus (one-hot digit enables plus a shared segment vector) and debounces each digit's pattern.
- Translates each stable pattern back into its 4-bit hex nibble and holds one nibble per digit.
- Used by self-check logic and by benches to read back what a display driver is showing.

---
 rtl/seven_seg_reader.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/seven_seg_reader.sv
// seven_seg_reader: snoops a multiplexed 7-segment bus and recovers the hex
// nibble shown on each digit once its pattern has been stable long enough.
// Optional macro SEVEN_SEG_READER_ACTIVE_LOW_EN: treat digit_en and dispseg
// as active-low (common-anode boards); they are inverted ahead of the input
// registers and nothing else changes.
module seven_seg_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [6:0]            dispseg,
  output logic [4*DIGITS-1:0]   nibbles,
  output logic [DIGITS-1:0]     valid,
  output logic [DIGITS-1:0]     err,
  output logic                  update,
  output logic [2:0]            update_digit
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] TRACK = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  logic [DIGITS-1:0] en_in;
  logic [6:0]        seg_in;

`ifdef SEVEN_SEG_READER_ACTIVE_LOW_EN
  assign en_in  = ~digit_en;
  assign seg_in = ~dispseg;
`else
  assign en_in  = digit_en;
  assign seg_in = dispseg;
`endif

  logic [DIGITS-1:0] s_en, p_en;
  logic [6:0]        s_seg, p_seg;
  logic [1:0]        state, state_n;
  logic [CW-1:0]     count, count_n;
  logic              commit;
  logic              legal, same;
  logic [2:0]        idx;
  logic              hit;
  logic [3:0]        code;

  // Pattern -> {recognized, nibble}; anything outside the 16 glyphs misses.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'b0111111: decode = {1'b1, 4'h0};
      7'b0000110: decode = {1'b1, 4'h1};
      7'b1011011: decode = {1'b1, 4'h2};
      7'b1001111: decode = {1'b1, 4'h3};
      7'b1100110: decode = {1'b1, 4'h4};
      7'b1101101: decode = {1'b1, 4'h5};
      7'b1111101: decode = {1'b1, 4'h6};
      7'b0000111: decode = {1'b1, 4'h7};
      7'b1111111: decode = {1'b1, 4'h8};
      7'b1100111: decode = {1'b1, 4'h9};
      7'b1110111: decode = {1'b1, 4'hA};
      7'b1111100: decode = {1'b1, 4'hB};
      7'b0111001: decode = {1'b1, 4'hC};
      7'b1011110: decode = {1'b1, 4'hD};
      7'b1111001: decode = {1'b1, 4'hE};
      7'b1110001: decode = {1'b1, 4'hF};
      default:    decode = {1'b0, 4'h0};
    endcase
  endfunction

  // Sample classification: exactly one enable, and equality with the sample
  // seen on the previous edge (enable change alone counts as a change).
  always_comb begin
    legal = (s_en != '0) && ((s_en & (s_en - 1'b1)) == '0);
    same  = (s_en == p_en) && (s_seg == p_seg);
    {hit, code} = decode(s_seg);
  end

  // Index of the single active enable bit.
  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < DIGITS; i++)
      if (s_en[i]) idx = 3'(i);
  end

  // Debounce FSM: commit on the STABLE_CYCLES-th identical legal sample,
  // then hold so a steady pattern commits only once.
  always_comb begin
    state_n = state;
    count_n = count;
    commit  = 1'b0;
    if (!legal) begin
      state_n = IDLE;
      count_n = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = TRACK;
          count_n = CW'(1);
        end
        TRACK: begin
          if (!same) begin
            count_n = CW'(1);
          end else if (count >= CW'(STABLE_CYCLES - 1)) begin
            commit  = 1'b1;
            state_n = HOLD;
            count_n = CW'(STABLE_CYCLES);
          end else begin
            count_n = count + CW'(1);
          end
        end
        HOLD: begin
          if (!same) begin
            state_n = TRACK;
            count_n = CW'(1);
          end
        end
        default: begin
          state_n = IDLE;
          count_n = '0;
        end
      endcase
    end
  end

  // Input registers, FSM state and per-digit result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_en         <= '0;
      s_seg        <= '0;
      p_en         <= '0;
      p_seg        <= '0;
      state        <= IDLE;
      count        <= '0;
      nibbles      <= '0;
      valid        <= '0;
      err          <= '0;
      update       <= 1'b0;
      update_digit <= 3'd0;
    end else begin
      s_en         <= en_in;
      s_seg        <= seg_in;
      p_en         <= s_en;
      p_seg        <= s_seg;
      state        <= state_n;
      count        <= count_n;
      update       <= commit;
      update_digit <= commit ? idx : 3'd0;
      for (int i = 0; i < DIGITS; i++) begin
        if (commit && s_en[i]) begin
          if (hit) nibbles[4*i +: 4] <= code;
          valid[i] <= hit;
          err[i]   <= ~hit;
        end
      end
    end
  end

endmodule
